// File: rtl/code_conv_pkg.sv
// Shared constants and types for the digit-serial decimal code converter.
package code_conv_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [1:0] MODE_8421 = 2'd0;
    localparam logic [1:0] MODE_2421 = 2'd1;
    localparam logic [1:0] MODE_EX3  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_rsvd(input logic [1:0] mode);
        return mode == MODE_RSVD;
    endfunction

endpackage

// File: rtl/digit_code_xlat.sv
// Combinational single-digit converter between 8421, 2421 and excess-3.
// A digit is first decoded to its decimal value 0-9, then re-encoded.
module digit_code_xlat
    import code_conv_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_nibble,
    input  logic [1:0]         i_src_mode,
    input  logic [1:0]         i_dst_mode,
    output logic [DIGIT_W-1:0] o_nibble,
    output logic               o_err
);

    logic [DIGIT_W-1:0] w_value;
    logic               w_src_bad;

    // Decode the source nibble to a decimal value, flagging unused codes.
    always_comb begin
        w_value   = '0;
        w_src_bad = 1'b0;
        case (i_src_mode)
            MODE_8421: begin
                if (i_nibble <= 4'd9) w_value = i_nibble;
                else                  w_src_bad = 1'b1;
            end
            MODE_2421: begin
                if (i_nibble <= 4'd4)       w_value = i_nibble;
                else if (i_nibble >= 4'd11) w_value = i_nibble - 4'd6;
                else                        w_src_bad = 1'b1;
            end
            MODE_EX3: begin
                if (i_nibble >= 4'd3 && i_nibble <= 4'd12) w_value = i_nibble - 4'd3;
                else                                       w_src_bad = 1'b1;
            end
            default: w_src_bad = 1'b1;
        endcase
    end

    // Encode the decimal value in the destination code; errors force 0000.
    always_comb begin
        o_nibble = '0;
        o_err    = w_src_bad || is_rsvd(i_dst_mode);
        if (!o_err) begin
            case (i_dst_mode)
                MODE_8421: o_nibble = w_value;
                MODE_2421: o_nibble = (w_value <= 4'd4) ? w_value : w_value + 4'd6;
                MODE_EX3:  o_nibble = w_value + 4'd3;
                default:   o_nibble = '0;
            endcase
        end
    end

endmodule

// File: rtl/bcd_code_xlat_seq.sv
// Digit-serial decimal code converter: captures a word, converts one digit
// per clock through a shared digit_code_xlat, then holds the result until
// the downstream handshake completes.
module bcd_code_xlat_seq
    import code_conv_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_code,
    input  logic [1:0]            src_mode,
    input  logic [1:0]            dst_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_code,
    output logic [DIGITS-1:0]     out_err
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_cnt;
    logic [4*DIGITS-1:0]   r_in;
    logic [1:0]            r_src;
    logic [1:0]            r_dst;
    logic [4*DIGITS-1:0]   r_out;
    logic [DIGITS-1:0]     r_err;

    logic                  w_accept;
    logic                  w_last;
    logic [DIGIT_W-1:0]    w_nib_in;
    logic [DIGIT_W-1:0]    w_nib_out;
    logic                  w_nib_err;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == CW'(DIGITS - 1));

    // Select the digit currently addressed by the counter.
    always_comb begin
        w_nib_in = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_cnt == CW'(i)) w_nib_in = r_in[4*i +: 4];
        end
    end

    digit_code_xlat u_xlat (
        .i_nibble   (w_nib_in),
        .i_src_mode (r_src),
        .i_dst_mode (r_dst),
        .o_nibble   (w_nib_out),
        .o_err      (w_nib_err)
    );

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CONV;
            CONV:    if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs; in_ready is held low while reset is asserted.
    always_comb begin
        in_ready  = (r_state == IDLE) && !rst;
        out_valid = (r_state == DONE);
    end

    // Capture on acceptance, then write one converted digit per CONV cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_in  <= '0;
            r_src <= MODE_8421;
            r_dst <= MODE_8421;
            r_out <= '0;
            r_err <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_in  <= in_code;
                        r_src <= src_mode;
                        r_dst <= dst_mode;
                        r_cnt <= '0;
                        r_out <= '0;
                        r_err <= '0;
                    end
                end
                CONV: begin
                    for (int unsigned i = 0; i < DIGITS; i++) begin
                        if (r_cnt == CW'(i)) begin
                            r_out[4*i +: 4] <= w_nib_out;
                            r_err[i]        <= w_nib_err;
                        end
                    end
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_code = r_out;
    assign out_err  = r_err;

endmodule

// File: tb/tb_bcd_code_xlat_seq.sv
// Directed bench for bcd_code_xlat_seq (DIGITS=4 and DIGITS=1) and an
// exhaustive sweep of digit_code_xlat against code tables.
module tb_bcd_code_xlat_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_code, out_code;
    logic [1:0]  src_mode, dst_mode;
    logic [3:0]  out_err;

    logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
    logic [3:0]  d1_in_code, d1_out_code;
    logic [1:0]  d1_src_mode, d1_dst_mode;
    logic [0:0]  d1_out_err;

    logic [3:0]  ux_nib_in, ux_nib_out;
    logic [1:0]  ux_src, ux_dst;
    logic        ux_err;

    int n_checks = 0;
    int n_fails  = 0;

    // Code tables: index [mode][decimal value] -> nibble.
    logic [3:0] tbl [0:2][0:9] = '{
        '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9},
        '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF},
        '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC}
    };

    bcd_code_xlat_seq #(.DIGITS(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .src_mode  (src_mode),
        .dst_mode  (dst_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_err   (out_err)
    );

    bcd_code_xlat_seq #(.DIGITS(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d1_in_valid),
        .in_ready  (d1_in_ready),
        .in_code   (d1_in_code),
        .src_mode  (d1_src_mode),
        .dst_mode  (d1_dst_mode),
        .out_valid (d1_out_valid),
        .out_ready (d1_out_ready),
        .out_code  (d1_out_code),
        .out_err   (d1_out_err)
    );

    digit_code_xlat u_unit (
        .i_nibble   (ux_nib_in),
        .i_src_mode (ux_src),
        .i_dst_mode (ux_dst),
        .o_nibble   (ux_nib_out),
        .o_err      (ux_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer a word, check clearing at acceptance, latency and result.
    task automatic run_word(input string tag, input logic [15:0] code,
                            input logic [1:0] s, input logic [1:0] d,
                            input logic [15:0] ecode, input logic [3:0] eerr);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_code  = code;
        src_mode = s;
        dst_mode = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_code  = ~code;
        src_mode = ~s;
        dst_mode = ~d;
        check({tag, ".clr_code"}, 32'(out_code), 32'd0);
        check({tag, ".clr_err"}, 32'(out_err), 32'd0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'd4);
        check({tag, ".code"}, 32'(out_code), 32'(ecode));
        check({tag, ".err"}, 32'(out_err), 32'(eerr));
    endtask

    task automatic finish_word(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".ov_low"}, 32'(out_valid), 32'd0);
        check({tag, ".ir_high"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] held_code;
        logic [3:0]  held_err;
        logic [3:0]  exp_nib;
        logic        exp_err;
        int          lat;
        int          val;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        in_code = '0; src_mode = '0; dst_mode = '0;
        d1_in_valid = 1'b0; d1_out_ready = 1'b0;
        d1_in_code = '0; d1_src_mode = '0; d1_dst_mode = '0;
        ux_nib_in = '0; ux_src = '0; ux_dst = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_code", 32'(out_code), 32'd0);
        check("rst.out_err", 32'(out_err), 32'd0);
        check("rst.d1_out_valid", 32'(d1_out_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("rst.in_ready_after", 32'(in_ready), 32'd1);

        // 2421 -> excess-3: digits 1,5,8,9
        run_word("w2421_ex3", 16'h1BEF, 2'd1, 2'd2, 16'h48BC, 4'b0000);
        finish_word("w2421_ex3");

        // 8421 -> 2421 with an invalid digit 1, then hold in DONE
        run_word("w8421_2421", 16'h12A4, 2'd0, 2'd1, 16'h1204, 4'b0010);
        held_code = 16'h1204;
        held_err  = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.in_ready", 32'(in_ready), 32'd0);
            check("bp.code", 32'(out_code), 32'(held_code));
            check("bp.err", 32'(out_err), 32'(held_err));
            if (i == 5) begin
                in_valid = 1'b1; in_code = 16'h9999; src_mode = 2'd0; dst_mode = 2'd0;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        finish_word("bp");
        @(negedge clk);
        check("bp.no_accept_ov", 32'(out_valid), 32'd0);
        check("bp.no_accept_ir", 32'(in_ready), 32'd1);

        // 2421 invalid sweep to 8421
        run_word("w2421_inv", 16'h0505, 2'd1, 2'd0, 16'h0000, 4'b0101);
        finish_word("w2421_inv");

        // Reset mid-conversion after two digits
        @(negedge clk);
        in_code = 16'h4321; src_mode = 2'd0; dst_mode = 2'd0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("abort.partial", 32'(out_code), 32'h0021);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.out_code", 32'(out_code), 32'd0);
        check("abort.out_err", 32'(out_err), 32'd0);
        check("abort.in_ready_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort.in_ready", 32'(in_ready), 32'd1);
        run_word("wex3_8421", 16'h0039, 2'd2, 2'd0, 16'h0006, 4'b1100);
        finish_word("wex3_8421");

        // Reserved modes
        run_word("rsvd_src", 16'h1234, 2'd3, 2'd0, 16'h0000, 4'b1111);
        finish_word("rsvd_src");
        run_word("rsvd_dst", 16'h1234, 2'd0, 2'd3, 16'h0000, 4'b1111);
        finish_word("rsvd_dst");

        // Pass-through still validates
        run_word("pass_ex3", 16'h3C2D, 2'd2, 2'd2, 16'h3C00, 4'b0011);
        finish_word("pass_ex3");

        // DIGITS=1: 8421 9 -> excess-3 C, latency 1
        @(negedge clk);
        check("d1.in_ready", 32'(d1_in_ready), 32'd1);
        d1_in_code = 4'h9; d1_src_mode = 2'd0; d1_dst_mode = 2'd2; d1_in_valid = 1'b1;
        @(posedge clk);
        #1;
        d1_in_valid = 1'b0; d1_in_code = 4'h0; d1_src_mode = 2'd3;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (d1_out_valid) begin
                lat = k;
                break;
            end
        end
        check("d1.latency", 32'(lat), 32'd1);
        check("d1.code", 32'(d1_out_code), 32'hC);
        check("d1.err", 32'(d1_out_err), 32'd0);
        @(negedge clk);
        d1_out_ready = 1'b1;
        @(posedge clk);
        #1;
        d1_out_ready = 1'b0;
        check("d1.ov_low", 32'(d1_out_valid), 32'd0);
        check("d1.ir_high", 32'(d1_in_ready), 32'd1);

        // Exhaustive single-digit sweep against the code tables
        for (int s = 0; s < 4; s++) begin
            for (int d = 0; d < 4; d++) begin
                for (int n = 0; n < 16; n++) begin
                    ux_src    = 2'(s);
                    ux_dst    = 2'(d);
                    ux_nib_in = 4'(n);
                    #1;
                    val = -1;
                    if (s < 3) begin
                        for (int v = 0; v < 10; v++) begin
                            if (tbl[s][v] == 4'(n)) val = v;
                        end
                    end
                    if (val >= 0 && d < 3) begin
                        exp_nib = tbl[d][val];
                        exp_err = 1'b0;
                    end else begin
                        exp_nib = 4'h0;
                        exp_err = 1'b1;
                    end
                    check($sformatf("unit.s%0d.d%0d.n%0h.nib", s, d, n), 32'(ux_nib_out), 32'(exp_nib));
                    check($sformatf("unit.s%0d.d%0d.n%0h.err", s, d, n), 32'(ux_err), 32'(exp_err));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
